// File: rtl/imem_boot_loader.sv
// Byte-stream instruction image loader: packs big-endian bytes into words, writes them to
// instruction memory, and holds the processor in reset until the whole image is stored.
module imem_boot_loader #(
    parameter int unsigned D_WIDTH   = 32,
    parameter int unsigned SA_WIDTH  = 8,
    parameter int unsigned NUM_WORDS = 256
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic [7:0]          i_byte_in,
    input  logic                i_byte_valid,
    output logic                o_byte_ready,
    output logic [D_WIDTH-1:0]  o_m_di,
    output logic [SA_WIDTH-1:0] o_mi_addr,
    output logic                o_m_enb,
    output logic                o_m_web,
    output logic                o_rst_m,
    output logic                o_gpp_rst,
    output logic                o_busy,
    output logic                o_load_done
);

    typedef enum logic [2:0] {StIdle, StClear, StLoad, StWrite, StDone} state_e;

    localparam logic [SA_WIDTH:0] LastIdx = (SA_WIDTH + 1)'(NUM_WORDS - 1);

    state_e                r_state;
    logic [SA_WIDTH:0]     r_idx;
    logic [1:0]            r_cnt;
    logic [D_WIDTH-9:0]    r_buf;
    logic                  r_byte_ready;
    logic [D_WIDTH-1:0]    r_m_di;
    logic [SA_WIDTH-1:0]   r_mi_addr;
    logic                  r_m_enb;
    logic                  r_m_web;
    logic                  r_rst_m;
    logic                  r_gpp_rst;
    logic                  r_busy;
    logic                  r_load_done;

    wire w_accept = i_byte_valid && r_byte_ready;

    // Outputs are registered: each transition sets the values seen in the state being entered.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_buf        <= '0;
            r_byte_ready <= 1'b0;
            r_m_di       <= '0;
            r_mi_addr    <= '0;
            r_m_enb      <= 1'b0;
            r_m_web      <= 1'b0;
            r_rst_m      <= 1'b0;
            r_gpp_rst    <= 1'b1;
            r_busy       <= 1'b0;
            r_load_done  <= 1'b0;
        end else begin
            r_m_enb <= 1'b0;
            r_m_web <= 1'b0;
            r_rst_m <= 1'b0;
            case (r_state)
                StIdle, StDone: begin
                    if (i_start) begin
                        r_state     <= StClear;
                        r_rst_m     <= 1'b1;
                        r_busy      <= 1'b1;
                        r_gpp_rst   <= 1'b1;
                        r_load_done <= 1'b0;
                    end
                end
                StClear: begin
                    r_idx        <= '0;
                    r_cnt        <= '0;
                    r_state      <= StLoad;
                    r_byte_ready <= 1'b1;
                end
                StLoad: begin
                    if (w_accept) begin
                        if (r_cnt == 2'd3) begin
                            r_m_di       <= {r_buf, i_byte_in};
                            r_mi_addr    <= r_idx[SA_WIDTH-1:0];
                            r_m_enb      <= 1'b1;
                            r_m_web      <= 1'b1;
                            r_byte_ready <= 1'b0;
                            r_cnt        <= '0;
                            r_state      <= StWrite;
                        end else begin
                            r_buf <= {r_buf[D_WIDTH-17:0], i_byte_in};
                            r_cnt <= r_cnt + 2'd1;
                        end
                    end
                end
                StWrite: begin
                    if (r_idx == LastIdx) begin
                        r_state     <= StDone;
                        r_gpp_rst   <= 1'b0;
                        r_load_done <= 1'b1;
                        r_busy      <= 1'b0;
                    end else begin
                        r_idx        <= r_idx + 1'b1;
                        r_state      <= StLoad;
                        r_byte_ready <= 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_byte_ready = r_byte_ready;
    assign o_m_di       = r_m_di;
    assign o_mi_addr    = r_mi_addr;
    assign o_m_enb      = r_m_enb;
    assign o_m_web      = r_m_web;
    assign o_rst_m      = r_rst_m;
    assign o_gpp_rst    = r_gpp_rst;
    assign o_busy       = r_busy;
    assign o_load_done  = r_load_done;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench: a single-word loader instance and a full 256-word instance share clock/reset.
module tb_imem_boot_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Full-image instance
    logic        start = 1'b0, valid = 1'b0;
    logic [7:0]  bin = 8'h00;
    logic        ready, m_enb, m_web, rst_m, gpp_rst, busy, load_done;
    logic [31:0] m_di;
    logic [7:0]  addr;

    // Single-word instance
    logic        start1 = 1'b0, valid1 = 1'b0;
    logic [7:0]  bin1 = 8'h00;
    logic        ready1, m_enb1, m_web1, rst_m1, gpp_rst1, busy1, load_done1;
    logic [31:0] m_di1;
    logic [7:0]  addr1;

    imem_boot_loader #(.D_WIDTH(32), .SA_WIDTH(8), .NUM_WORDS(256)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_byte_in(bin), .i_byte_valid(valid),
        .o_byte_ready(ready), .o_m_di(m_di), .o_mi_addr(addr), .o_m_enb(m_enb),
        .o_m_web(m_web), .o_rst_m(rst_m), .o_gpp_rst(gpp_rst), .o_busy(busy),
        .o_load_done(load_done)
    );

    imem_boot_loader #(.D_WIDTH(32), .SA_WIDTH(8), .NUM_WORDS(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start1), .i_byte_in(bin1), .i_byte_valid(valid1),
        .o_byte_ready(ready1), .o_m_di(m_di1), .o_mi_addr(addr1), .o_m_enb(m_enb1),
        .o_m_web(m_web1), .o_rst_m(rst_m1), .o_gpp_rst(gpp_rst1), .o_busy(busy1),
        .o_load_done(load_done1)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int c0     = 0;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {31'd0, ready}, 32'd0);
        check({tag, "_di"}, m_di, 32'd0);
        check({tag, "_addr"}, {24'd0, addr}, 32'd0);
        check({tag, "_enb"}, {30'd0, m_enb, m_web}, 32'd0);
        check({tag, "_rstm"}, {31'd0, rst_m}, 32'd0);
        check({tag, "_gpprst"}, {31'd0, gpp_rst}, 32'd1);
        check({tag, "_busy_done"}, {30'd0, busy, load_done}, 32'd0);
    endtask

    // Sends one word on the full-image instance, with n_stall idle cycles scattered between
    // bytes, and checks the resulting write; ends after the WRITE cycle.
    task automatic send_word(input logic [31:0] w, input int unsigned n_stall,
                             input logic [7:0] exp_addr);
        int st[4];
        for (int k = 0; k < 4; k++) st[k] = 0;
        for (int s = 0; s < int'(n_stall); s++) st[$urandom_range(1, 3)]++;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < st[k]; j++) begin
                valid = 1'b0;
                step();
                check("stall_no_write", {31'd0, m_enb}, 32'd0);
            end
            bin   = w[31-8*k -: 8];
            valid = 1'b1;
            step();
            if (k < 3) check("early_write", {31'd0, m_enb}, 32'd0);
        end
        valid = 1'b0;
        check("wr_enb", {30'd0, m_enb, m_web}, 32'd3);
        check("wr_addr", {24'd0, addr}, {24'd0, exp_addr});
        check("wr_data", m_di, w);
        check("wr_ready_low", {31'd0, ready}, 32'd0);
        check("wr_cpu_held", {31'd0, gpp_rst}, 32'd1);
        step();
        check("post_wr_enb", {31'd0, m_enb}, 32'd0);
    endtask

    initial begin
        logic [31:0] w1;

        // Reset with Start held high: nothing may start.
        rst = 1'b1; start = 1'b1; start1 = 1'b1;
        step();
        check_reset_outputs("rst_c1");
        step();
        check_reset_outputs("rst_c2");
        rst = 1'b0; start = 1'b0; start1 = 1'b0;
        step();
        check_reset_outputs("idle");
        check("idle1_busy", {31'd0, busy1}, 32'd0);

        // Single word on the NUM_WORDS=1 instance.
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        check("sw_clear_rstm", {31'd0, rst_m1}, 32'd1);
        check("sw_clear_busy", {31'd0, busy1}, 32'd1);
        check("sw_clear_ready", {31'd0, ready1}, 32'd0);
        step();
        check("sw_load_rstm", {31'd0, rst_m1}, 32'd0);
        check("sw_load_ready", {31'd0, ready1}, 32'd1);
        w1 = 32'h2008_0005;
        for (int k = 0; k < 4; k++) begin
            bin1 = w1[31-8*k -: 8]; valid1 = 1'b1;
            step();
            check("sw_rstm_once", {31'd0, rst_m1}, 32'd0);
        end
        valid1 = 1'b0;
        check("sw_enb", {30'd0, m_enb1, m_web1}, 32'd3);
        check("sw_addr", {24'd0, addr1}, 32'd0);
        check("sw_data", m_di1, 32'h2008_0005);
        check("sw_cpu_held", {31'd0, gpp_rst1}, 32'd1);
        step();
        check("sw_done_enb", {31'd0, m_enb1}, 32'd0);
        check("sw_done_gpp", {31'd0, gpp_rst1}, 32'd0);
        check("sw_done_flag", {31'd0, load_done1}, 32'd1);
        check("sw_done_busy", {31'd0, busy1}, 32'd0);
        check("sw_hold_data", m_di1, 32'h2008_0005);

        // Restart from DONE, with a stray Start during the load.
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        check("rs_gpp", {31'd0, gpp_rst1}, 32'd1);
        check("rs_done", {31'd0, load_done1}, 32'd0);
        check("rs_rstm", {31'd0, rst_m1}, 32'd1);
        step();
        w1 = 32'hAABB_CCDD;
        for (int k = 0; k < 4; k++) begin
            bin1 = w1[31-8*k -: 8]; valid1 = 1'b1; start1 = (k == 1);
            step();
            check("rs_ignore_start", {31'd0, rst_m1}, 32'd0);
        end
        valid1 = 1'b0; start1 = 1'b0;
        check("rs_enb", {31'd0, m_enb1}, 32'd1);
        check("rs_addr", {24'd0, addr1}, 32'd0);
        check("rs_data", m_di1, 32'hAABB_CCDD);
        step();
        check("rs_done2", {31'd0, load_done1}, 32'd1);

        // Full 256-word image, continuous bytes.
        start = 1'b1;
        step();
        start = 1'b0;
        c0 = cyc;
        check("fi_rstm", {31'd0, rst_m}, 32'd1);
        step();
        for (int i = 0; i < 256; i++) begin
            if (i == 255) check("fi_not_done_yet", {31'd0, load_done}, 32'd0);
            send_word(32'h1000_0000 + i, 0, 8'(i));
        end
        check("fi_done", {31'd0, load_done}, 32'd1);
        check("fi_gpp", {31'd0, gpp_rst}, 32'd0);
        check("fi_latency", cyc - c0, 32'd1281);

        // Backpressure on a fresh load, then reset in the middle of word 5.
        start = 1'b1;
        step();
        start = 1'b0;
        check("bp_rstm", {31'd0, rst_m}, 32'd1);
        step();
        for (int i = 0; i < 5; i++) send_word(32'h5A00_0000 + 32'(i * 32'h0101), 3, 8'(i));
        bin = 8'hEE; valid = 1'b1;
        step();
        bin = 8'hDD;
        step();
        valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        check("mr_enb", {31'd0, m_enb}, 32'd0);
        check("mr_gpp", {31'd0, gpp_rst}, 32'd1);
        check("mr_busy", {31'd0, busy}, 32'd0);
        check("mr_ready", {31'd0, ready}, 32'd0);
        step();
        check("mr_idle_busy", {31'd0, busy}, 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        send_word(32'hCAFE_F00D, 0, 8'd0);
        send_word(32'h1234_5678, 2, 8'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Byte-stream program loader placed directly upstream of the GPP_TOP memory-load port. It receives an instruction image as a handshaked byte stream, packs four bytes into a 32-bit word, and issues one-word writes on the M_di / MI_Addr / M_enb / M_web bus. It pulses the memory reset before loading and holds the processor in reset until the whole image is written. It replaces the bench-only load loop with synthesizable logic.

## Interface
- D_WIDTH, 32: instruction word width; fixed at 4 bytes.
- SA_WIDTH, 8: memory address width.
- NUM_WORDS, 256: number of words per image; must be ≤ 2^SA_WIDTH.
- Clk  in  1  system clock; all logic on rising edge.
- Rst  in  1  synchronous, active-high reset.
- Start  in  1  one-cycle load request; sampled only in IDLE and DONE.
- Byte_In  in  8  stream data.
- Byte_Valid  in  1  Byte_In is valid.
- Byte_Ready  out  1  loader accepts a byte this cycle.
- M_di  out  D_WIDTH  write data to memory.
- MI_Addr  out  SA_WIDTH  write address.
- M_enb  out  1  memory enable.
- M_web  out  1  memory write enable.
- Rst_M  out  1  memory reset pulse.
- Gpp_Rst  out  1  processor reset; drives GPP_TOP Rst.
- Busy  out  1  a load is in progress (CLEAR, LOAD or WRITE).
- Load_Done  out  1  image is complete and the processor has been released.

## Operation
- All outputs are registered. Values after reset: Byte_Ready=0, M_di=0, MI_Addr=0, M_enb=0, M_web=0, Rst_M=0, Gpp_Rst=1, Busy=0, Load_Done=0.
- Internal state: word index (SA_WIDTH+1 bits), byte counter (2 bits), 24-bit shift buffer.
- FSM states:
  - IDLE: Gpp_Rst=1. On Start, go to CLEAR.
  - CLEAR: lasts exactly 1 cycle. Rst_M=1. Index and byte counter are zeroed. Next state is LOAD.
  - LOAD: Byte_Ready=1. A byte is accepted when Byte_Valid && Byte_Ready.
    - Byte order is big-endian: the first byte becomes M_di[31:24] and the fourth becomes M_di[7:0].
    - When the 4th byte is accepted, M_di is formed from the buffer plus Byte_In, MI_Addr is set to the index, and the FSM goes to WRITE.
  - WRITE: lasts exactly 1 cycle. M_enb=1, M_web=1, Byte_Ready=0.
    - If index == NUM_WORDS-1, go to DONE.
    - Otherwise increment the index and return to LOAD.
  - DONE: Gpp_Rst=0, Load_Done=1, Busy=0.
    - On Start, go to CLEAR. In that same transition Gpp_Rst=1 and Load_Done=0, so the CPU is re-held before any memory write.
- M_enb and M_web are 0 in every state except WRITE. M_di and MI_Addr hold their last values outside WRITE.
- Start is ignored while Busy. Byte_Valid is ignored outside LOAD; bytes offered then are not consumed.
- Rst in any state returns to the reset values on the next edge. A partial word is discarded and no write is issued in that cycle. Rst has priority over Start.

## Timing
- Start at edge t gives: CLEAR (Rst_M=1) during t+1, then LOAD with Byte_Ready=1 from t+2.
- With Byte_Valid held high, each word takes 5 cycles: 4 accept cycles + 1 WRITE cycle.
- A full image with continuous valid bytes takes 1 + 5·NUM_WORDS cycles from Start to DONE. For 256 words that is 1281 cycles.
- Gpp_Rst falls in the first DONE cycle, one cycle after the final WRITE. The memory write therefore completes before the CPU leaves reset.
- Stalls: Byte_Valid low in LOAD holds the byte counter and buffer, with no timeout.
- Byte_Ready falls one cycle after the 4th accept (in WRITE) and rises again the following cycle.

## Test plan
- Reset values: hold Rst=1 for 2 cycles with Start=1 → all outputs at reset values, FSM stays in IDLE, no Rst_M pulse.
- Single word: NUM_WORDS=1, Start, then bytes 0x20,0x08,0x00,0x05 back-to-back →
  - one WRITE cycle with MI_Addr=0 and M_di=0x20080005;
  - the next cycle has Gpp_Rst=0 and Load_Done=1;
  - Rst_M was high for exactly 1 cycle after Start.
- Full image: NUM_WORDS=256, word i = 0x1000_0000+i →
  - 256 WRITE pulses at addresses 0..255 with matching data;
  - Load_Done asserted 1281 cycles after Start.
- Backpressure: drop Byte_Valid for 3 random cycles inside each word → data and addresses still correct; no write issued until the 4th byte is accepted.
- Reset mid-load: assert Rst after 2 bytes of word 5 → next cycle M_enb=0 and Gpp_Rst=1. A new Start then reloads from address 0, and the first written word uses only bytes from the new stream.
- Restart from DONE: Start while Load_Done=1 → Gpp_Rst=1 and Load_Done=0 on the next edge, Rst_M pulses, and writes restart at MI_Addr=0. Start asserted mid-load is ignored.
